stim_prbs_checker: RTL and testbench
====================================

Name: stim_prbs_checker

Overview:
- Receive-side counterpart of the stimulus generator. Checks the 2-lane serial pattern coming back on DIN against a local PRBS7 reference.
- Each lane: self-seeds from the incoming stream, acquires lock, then counts checked bits and bit errors.
- Sits at the loopback/receive end of the clock-skew test path. Exports lock status and per-lane receive/error counters for host readout.

Parameters:
- NLANE, 2, number of serial lanes checked in parallel.
- RCW, 30, per-lane received-bit counter width; RECV_CNT is NLANE*RCW bits.
- ECW, 32, per-lane error counter width; ERR_CNT is NLANE*ECW bits.
- LOCK_CNT, 16, consecutive matching bits required in CHECK before entering LOCKED.
- UNLOCK_ERR, 8, consecutive mismatching bits in LOCKED that force return to HUNT.

Ports:
- CLK  in  1  single clock; all state on rising edge.
- RSTX  in  1  asynchronous, active-low reset.
- EN  in  1  checker enable; low forces all lanes to HUNT, counters hold.
- CLR  in  1  synchronous counter clear, one-cycle pulse or level.
- DIN  in  NLANE  one serial bit per lane per cycle.
- LOCKED  out  NLANE  per-lane lock status.
- RECV_CNT  out  NLANE*RCW  lane i at [i*RCW +: RCW]; bits checked while LOCKED.
- ERR_CNT  out  NLANE*ECW  lane i at [i*ECW +: ECW]; mismatches while LOCKED.

Behaviour:
- Reset (RSTX low, asynchronous): LOCKED=0, RECV_CNT=0, ERR_CNT=0, state=HUNT, seed/LFSR=0, input register=0.
- Pipeline: DIN captured in an input register at edge n; compared and counters/state updated at edge n+1. DIN-to-counter latency is 2 cycles.
- PRBS7 polynomial is x^7+x^6+1. Next bit = s[6]^s[5]; shift left, new bit into s[0].
- HUNT: shift the registered bit into the 7-bit seed. After 7 bits, load the local LFSR with the seed and go to CHECK with match count 0.
  - A seed of all zeros is invalid: stay in HUNT and restart seed collection.
- CHECK:
  - Local LFSR advances every cycle; the registered bit is compared with the expected bit.
  - Match increments the match count. Reaching LOCK_CNT goes to LOCKED.
  - Any mismatch returns to HUNT.
  - No counting in CHECK.
- LOCKED:
  - LOCKED=1 and the LFSR free-runs; every cycle RECV_CNT increments.
  - On mismatch, ERR_CNT also increments and the consecutive-error count increments; a match resets it to 0.
  - When the consecutive-error count reaches UNLOCK_ERR, go to HUNT and drop LOCKED.
  - The bit that triggers unlock is still counted in both counters.
- Clean stream: LOCKED rises 2 cycles after bit index 22 (7 seed + 16 check) is on DIN. The first counted bit is index 23.
- Counters saturate at all-ones and never wrap.
- CLR zeroes both counters of all lanes next edge. CLR wins over a simultaneous increment. CLR does not affect lock state.
- EN low: all lanes go to HUNT next edge, LOCKED=0, counters hold. Re-asserting EN restarts acquisition from HUNT.
- Lanes are fully independent; one lane losing lock does not affect the other.

Optional Feature:
- Macro: STIM_PRBS_CHECKER_LOL_CNT_EN.
- Defined: adds output LOL_CNT (NLANE*8). Per lane, it increments (saturating at 255) on each LOCKED->HUNT transition caused by UNLOCK_ERR. EN-forced drops do not count. Cleared by CLR and by reset.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package stim_chk_pkg:
  - state typedef with encodings HUNT=2'd0, CHECK=2'd1, LOCKED=2'd2.
  - PRBS7 tap constants (6, 5).
  - PRBS7 next-bit function.
- Sub-module stim_prbs_lane_chk: one lane, containing the state machine, LFSR, match/error run counters and saturating counters. It is instantiated NLANE times in a generate loop. The top holds only the port slicing and the shared CLR/EN fan-out.

Test Plan:
- Clean PRBS7 on both lanes from seed 7'h7F → LOCKED=2'b11 two cycles after bit 22. After 1000 more bits, RECV_CNT lanes = 1000 each and ERR_CNT = 0.
- Locked lane 0, single bit flip at bit 500 → ERR_CNT[lane0]=1, LOCKED stays 1. Lane 1 counters are unaffected.
- Locked lane 1, 8 consecutive inverted bits → LOCKED[1] falls after the 8th. ERR_CNT[lane1]=8 and RECV_CNT includes those 8. Lane 1 relocks 23 bits after a clean stream resumes.
- All-zero DIN for 100 cycles → LOCKED stays 0 and counters stay 0 (zero-seed rejection).
- Preload RECV_CNT near saturation with RCW=4: counter stops at 4'hF. CLR asserted on the same cycle as an error → both counters read 0 next cycle and LOCKED remains 1.
- RSTX pulsed low mid-LOCKED → all outputs 0 immediately, without waiting for a clock edge. After release, relock takes 23 bits plus 2 cycles. EN low for 1 cycle → LOCKED=0, counters hold, then relock.

Source files
------------

// File: rtl/stim_chk_pkg.sv
// Shared types and PRBS7 helpers for the receive-side PRBS checker.
package stim_chk_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // PRBS7 x^7 + x^6 + 1: feedback from state bits 6 and 5
  localparam int PRBS_TAP_A = 6;
  localparam int PRBS_TAP_B = 5;

  function automatic logic prbs7_next(input logic [6:0] s);
    return s[PRBS_TAP_A] ^ s[PRBS_TAP_B];
  endfunction

endpackage

// File: rtl/stim_prbs_lane_chk.sv
// One PRBS7 checker lane: seed hunt, lock qualification, locked counting.
// STIM_PRBS_CHECKER_LOL_CNT_EN adds a saturating loss-of-lock counter.
module stim_prbs_lane_chk
  import stim_chk_pkg::*;
#(
  parameter int RCW        = 30,
  parameter int ECW        = 32,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_ERR = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           clr,
  input  logic           din,
  output logic           locked,
  output logic [RCW-1:0] recv_cnt,
  output logic [ECW-1:0] err_cnt
`ifdef STIM_PRBS_CHECKER_LOL_CNT_EN
  ,
  output logic [7:0]     lol_cnt
`endif
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int EW = $clog2(UNLOCK_ERR + 1);

  chk_state_t    state, state_nxt;
  logic          din_q, din_vld;
  logic [6:0]    seed, seed_nxt, lfsr, lfsr_nxt;
  logic [2:0]    seed_cnt, seed_cnt_nxt;
  logic [MW-1:0] match_cnt, match_nxt;
  logic [EW-1:0] err_run, err_run_nxt;
  logic          exp_bit, mismatch, count_en, err_en, unlock;

  // din_vld keeps the reset/disabled contents of din_q out of the seed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q   <= 1'b0;
      din_vld <= 1'b0;
    end else begin
      din_q   <= din;
      din_vld <= en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      seed      <= '0;
      seed_cnt  <= '0;
      lfsr      <= '0;
      match_cnt <= '0;
      err_run   <= '0;
    end else begin
      state     <= state_nxt;
      seed      <= seed_nxt;
      seed_cnt  <= seed_cnt_nxt;
      lfsr      <= lfsr_nxt;
      match_cnt <= match_nxt;
      err_run   <= err_run_nxt;
    end
  end

  assign exp_bit  = prbs7_next(lfsr);
  assign mismatch = din_q ^ exp_bit;

  always_comb begin
    state_nxt    = state;
    seed_nxt     = seed;
    seed_cnt_nxt = seed_cnt;
    lfsr_nxt     = lfsr;
    match_nxt    = match_cnt;
    err_run_nxt  = err_run;
    count_en     = 1'b0;
    err_en       = 1'b0;
    unlock       = 1'b0;
    if (!en) begin
      state_nxt    = HUNT;
      seed_cnt_nxt = '0;
    end else if (din_vld) begin
      case (state)
        HUNT: begin
          seed_nxt = {seed[5:0], din_q};
          if (seed_cnt == 3'd6) begin
            seed_cnt_nxt = '0;
            // an all-zero seed would lock the LFSR at zero; keep hunting
            if (seed_nxt != 7'd0) begin
              lfsr_nxt  = seed_nxt;
              match_nxt = '0;
              state_nxt = CHECK;
            end
          end else begin
            seed_cnt_nxt = seed_cnt + 3'd1;
          end
        end
        CHECK: begin
          lfsr_nxt = {lfsr[5:0], exp_bit};
          if (mismatch) begin
            state_nxt    = HUNT;
            seed_cnt_nxt = '0;
          end else begin
            match_nxt = match_cnt + 1'b1;
            if (match_nxt == MW'(LOCK_CNT)) begin
              state_nxt   = LOCKED;
              err_run_nxt = '0;
            end
          end
        end
        LOCKED: begin
          lfsr_nxt = {lfsr[5:0], exp_bit};
          count_en = 1'b1;
          if (mismatch) begin
            err_en      = 1'b1;
            err_run_nxt = err_run + 1'b1;
            if (err_run_nxt == EW'(UNLOCK_ERR)) begin
              unlock       = 1'b1;
              state_nxt    = HUNT;
              seed_cnt_nxt = '0;
            end
          end else begin
            err_run_nxt = '0;
          end
        end
        default: begin
          state_nxt    = HUNT;
          seed_cnt_nxt = '0;
        end
      endcase
    end
  end

  assign locked = (state == LOCKED);

  // clear beats a same-cycle increment; both counters stick at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      recv_cnt <= '0;
      err_cnt  <= '0;
    end else if (clr) begin
      recv_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (count_en && (recv_cnt != '1)) recv_cnt <= recv_cnt + 1'b1;
      if (err_en && (err_cnt != '1))    err_cnt  <= err_cnt + 1'b1;
    end
  end

`ifdef STIM_PRBS_CHECKER_LOL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           lol_cnt <= '0;
    else if (clr)                         lol_cnt <= '0;
    else if (unlock && (lol_cnt != '1))   lol_cnt <= lol_cnt + 1'b1;
  end
`endif

endmodule

// File: rtl/stim_prbs_checker.sv
// Multi-lane PRBS7 receive checker: per-lane lock status and counters.
// STIM_PRBS_CHECKER_LOL_CNT_EN adds the LOL_CNT output (8 bits per lane).
module stim_prbs_checker #(
  parameter int NLANE      = 2,
  parameter int RCW        = 30,
  parameter int ECW        = 32,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_ERR = 8
) (
  input  logic                 CLK,
  input  logic                 RSTX,
  input  logic                 EN,
  input  logic                 CLR,
  input  logic [NLANE-1:0]     DIN,
  output logic [NLANE-1:0]     LOCKED,
  output logic [NLANE*RCW-1:0] RECV_CNT,
  output logic [NLANE*ECW-1:0] ERR_CNT
`ifdef STIM_PRBS_CHECKER_LOL_CNT_EN
  ,
  output logic [NLANE*8-1:0]   LOL_CNT
`endif
);

  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    stim_prbs_lane_chk #(
      .RCW        (RCW),
      .ECW        (ECW),
      .LOCK_CNT   (LOCK_CNT),
      .UNLOCK_ERR (UNLOCK_ERR)
    ) u_lane (
      .clk      (CLK),
      .rst_n    (RSTX),
      .en       (EN),
      .clr      (CLR),
      .din      (DIN[i]),
      .locked   (LOCKED[i]),
      .recv_cnt (RECV_CNT[i*RCW +: RCW]),
      .err_cnt  (ERR_CNT[i*ECW +: ECW])
`ifdef STIM_PRBS_CHECKER_LOL_CNT_EN
      ,
      .lol_cnt  (LOL_CNT[i*8 +: 8])
`endif
    );
  end

endmodule

// File: tb/tb_stim_prbs_checker.sv
// Scoreboard bench for stim_prbs_checker: directed PRBS7 streams, queued expectations.
module tb_stim_prbs_checker;

  localparam int NL   = 2;
  localparam int RCW  = 30;
  localparam int ECW  = 32;
  localparam int SRCW = 4;
  localparam int SECW = 4;

  logic                CLK = 1'b0;
  logic                RSTX = 1'b0;
  logic                EN = 1'b1;
  logic                CLR = 1'b0;
  logic [NL-1:0]       DIN = '0;
  logic [NL-1:0]       LOCKED, LOCKED_S;
  logic [NL*RCW-1:0]   RECV_CNT;
  logic [NL*ECW-1:0]   ERR_CNT;
  logic [NL*SRCW-1:0]  RECV_S;
  logic [NL*SECW-1:0]  ERR_S;
`ifdef STIM_PRBS_CHECKER_LOL_CNT_EN
  logic [NL*8-1:0]     LOL_CNT, LOL_S;
`endif

  stim_prbs_checker #(.NLANE(NL), .RCW(RCW), .ECW(ECW)) dut (
    .CLK(CLK), .RSTX(RSTX), .EN(EN), .CLR(CLR), .DIN(DIN),
    .LOCKED(LOCKED), .RECV_CNT(RECV_CNT), .ERR_CNT(ERR_CNT)
`ifdef STIM_PRBS_CHECKER_LOL_CNT_EN
    , .LOL_CNT(LOL_CNT)
`endif
  );

  // narrow-counter copy to reach saturation quickly
  stim_prbs_checker #(.NLANE(NL), .RCW(SRCW), .ECW(SECW)) dut_s (
    .CLK(CLK), .RSTX(RSTX), .EN(EN), .CLR(CLR), .DIN(DIN),
    .LOCKED(LOCKED_S), .RECV_CNT(RECV_S), .ERR_CNT(ERR_S)
`ifdef STIM_PRBS_CHECKER_LOL_CNT_EN
    , .LOL_CNT(LOL_S)
`endif
  );

  always #5 CLK = ~CLK;

  int edge_n = 0;
  always @(posedge CLK) edge_n <= edge_n + 1;

  typedef struct {
    int          cyc;
    int          sel;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nmis = 0;

  function automatic logic [63:0] actual(input int sel);
    logic [63:0] r;
    r = '0;
    case (sel)
      0: r = 64'(LOCKED);
      1: r = 64'(RECV_CNT[0 +: RCW]);
      2: r = 64'(RECV_CNT[RCW +: RCW]);
      3: r = 64'(ERR_CNT[0 +: ECW]);
      4: r = 64'(ERR_CNT[ECW +: ECW]);
      5: r = 64'(LOCKED_S);
      6: r = 64'(RECV_S[0 +: SRCW]);
      7: r = 64'(ERR_S[0 +: SECW]);
`ifdef STIM_PRBS_CHECKER_LOL_CNT_EN
      8: r = 64'(LOL_CNT[8 +: 8]);
      9: r = 64'(LOL_CNT[0 +: 8]);
`endif
      default: r = '1;
    endcase
    return r;
  endfunction

  function automatic void cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // cyc = edge after which the value must hold; now=1 means the edge just taken
  task automatic ex(input string name, input int sel, input logic [63:0] v, input bit now = 1'b0);
    exp_t e;
    e.cyc  = now ? edge_n : edge_n + 1;
    e.sel  = sel;
    e.val  = v;
    e.name = name;
    q.push_back(e);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= edge_n) begin
      e = q.pop_front();
      cmp(e.name, actual(e.sel), e.val);
    end
  end

  // per-lane PRBS7 source: emit s[6], shift in s[6]^s[5]
  logic [6:0] g [NL];

  task automatic step(input logic [NL-1:0] inv);
    for (int l = 0; l < NL; l++) begin
      DIN[l] = g[l][6] ^ inv[l];
      g[l]   = {g[l][5:0], g[l][6] ^ g[l][5]};
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int k;
    logic [NL-1:0] inv;

    g[0] = 7'h00;
    g[1] = 7'h00;
    repeat (2) @(posedge CLK);
    #1;
    ex("rst_locked", 0, 0, 1);
    ex("rst_recv0", 1, 0, 1);
    ex("rst_err1", 4, 0, 1);
    RSTX = 1'b1;

    // all-zero stream: every candidate seed is zero, never leaves HUNT
    for (k = 0; k < 100; k++) step('0);
    ex("zero_locked", 0, 0);
    ex("zero_recv0", 1, 0);
    ex("zero_recv1", 2, 0);
    ex("zero_err0", 3, 0);
    step('0);
    @(negedge CLK);
    #1;
    RSTX = 1'b0;
    @(posedge CLK);
    #1;
    RSTX = 1'b1;
    g[0] = 7'h7F;
    g[1] = 7'h7F;

    for (k = 0; k <= 1100; k++) begin
      inv = '0;
      if (k == 1030 || k == 1088) inv[0] = 1'b1;
      if ((k >= 1050 && k <= 1057) || k == 1095) inv[1] = 1'b1;
      CLR = (k == 1089);
      step(inv);
      case (k)
        21: ex("lock_pre", 0, 2'b00);
        22: begin
          ex("lock_at23", 0, 2'b11);
          ex("lock_s", 5, 2'b11);
        end
        30: ex("small_recv8", 6, 8);
        1022: begin
          ex("clean_recv0", 1, 1000);
          ex("clean_recv1", 2, 1000);
          ex("clean_err0", 3, 0);
          ex("clean_err1", 4, 0);
          ex("clean_locked", 0, 2'b11);
          ex("small_sat", 6, 15);
        end
        1030: begin
          ex("flip_err0", 3, 1);
          ex("flip_err1", 4, 0);
          ex("flip_locked", 0, 2'b11);
          ex("flip_recv0", 1, 1008);
          ex("flip_recv1", 2, 1008);
        end
        1056: begin
          ex("run7_locked", 0, 2'b11);
          ex("run7_err1", 4, 7);
        end
        1057: begin
          ex("run8_locked", 0, 2'b01);
          ex("run8_err1", 4, 8);
          ex("run8_recv1", 2, 1035);
          ex("run8_err0", 3, 1);
        end
        1079: ex("relock1_pre", 0, 2'b01);
        1080: ex("relock1", 0, 2'b11);
        1087: begin
          ex("relock1_recv1", 2, 1042);
          ex("relock1_recv0", 1, 1065);
`ifdef STIM_PRBS_CHECKER_LOL_CNT_EN
          ex("lol1", 8, 1);
          ex("lol0", 9, 0);
`endif
        end
        1089: begin
          ex("clr_recv0", 1, 0, 1);
          ex("clr_err0", 3, 0, 1);
          ex("clr_err1", 4, 0, 1);
          ex("clr_locked", 0, 2'b11, 1);
          ex("clr_s_recv", 6, 0, 1);
          ex("clr_s_err", 7, 0, 1);
          ex("clr_s_locked", 5, 2'b11, 1);
`ifdef STIM_PRBS_CHECKER_LOL_CNT_EN
          ex("clr_lol1", 8, 0, 1);
`endif
          ex("postclr_recv0", 1, 1);
          ex("postclr_err0", 3, 0);
        end
        1099: begin
          ex("pre_rst_recv0", 1, 11);
          ex("pre_rst_recv1", 2, 11);
          ex("pre_rst_err1", 4, 1);
        end
        default: ;
      endcase
    end
    CLR = 1'b0;

    // asynchronous reset mid-cycle, sampled before any clock edge
    @(negedge CLK);
    #1;
    RSTX = 1'b0;
    #1;
    cmp("arst_locked", 64'(LOCKED), 0);
    cmp("arst_recv0", 64'(RECV_CNT[0 +: RCW]), 0);
    cmp("arst_recv1", 64'(RECV_CNT[RCW +: RCW]), 0);
    cmp("arst_err1", 64'(ERR_CNT[ECW +: ECW]), 0);
    @(posedge CLK);
    #1;
    g[0] = 7'h35;
    g[1] = 7'h5A;
    RSTX = 1'b1;

    for (k = 0; k <= 41; k++) begin
      step('0);
      if (k == 21) ex("rst_relock_pre", 0, 2'b00);
      if (k == 22) ex("rst_relock", 0, 2'b11);
      if (k == 40) ex("rst_relock_recv0", 1, 18);
    end

    // one disabled cycle: drop lock, hold counters, restart acquisition
    EN = 1'b0;
    step('0);
    ex("en_locked", 0, 2'b00, 1);
    ex("en_hold_recv0", 1, 18, 1);
    ex("en_hold_err0", 3, 0, 1);
    EN = 1'b1;
    for (k = 0; k <= 25; k++) begin
      step('0);
      if (k == 21) ex("en_relock_pre", 0, 2'b00);
      if (k == 22) ex("en_relock", 0, 2'b11);
      if (k == 25) ex("en_relock_recv0", 1, 21);
    end

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    #1;
    if (q.size() != 0) begin
      nvec++;
      nmis++;
      $display("FAIL drain: %0d expectations pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
